// File: rtl/counter_share_ctrl_pkg.sv
// Shared definitions for the counter-sharing controller: FSM state encoding,
// direction codes and the default counter width.
package counter_ctrl_pkg;
    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;
endpackage

// File: rtl/counter_share_ctrl_if.sv
// Requester/counter bundle of the counter-sharing controller. The master
// modport is the controller side; the slave modport is the clients plus counter.
interface counter_share_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic [N_REQ-1:0] ack;
    logic [WIDTH-1:0] ack_count;
    logic             ack_sat;
    logic             ack_wrap;
    logic             busy;
    logic             increase;
    logic             decrease;
    logic             overflow_protect;
    logic [WIDTH-1:0] count_in;

    modport master (
        input  req, dir, count_in,
        output ack, ack_count, ack_sat, ack_wrap, busy,
               increase, decrease, overflow_protect
    );

    modport slave (
        output req, dir, count_in,
        input  ack, ack_count, ack_sat, ack_wrap, busy,
               increase, decrease, overflow_protect
    );
endinterface

// File: rtl/counter_share_ctrl_rr_arbiter.sv
// Round-robin request picker: first asserted request at or after ptr wins,
// wrapping modulo N_REQ. Purely combinational; grant is zero when disabled.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_REQ);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end
endmodule

// File: rtl/counter_share_ctrl.sv
// Arbitrates N_REQ requesters onto one external up/down counter: one pulse per
// granted op, then an ack carrying the post-update count and boundary status.
module counter_share_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter logic        PROTECT = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    counter_share_ctrl_if.master bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_grant;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ack_q;
    logic             dir_g;
    logic             inc_q;
    logic             dec_q;
    logic             busy_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] count_hold;
    logic             in_wait;
    logic             at_edge;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .enable (state == IDLE),
        .grant  (win_grant),
        .index  (win_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            dir_g      <= DIR_DN;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            busy_q     <= 1'b0;
            prev       <= '0;
            count_hold <= '0;
        end else begin
            ack_q <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q <= win_grant;
                        dir_g   <= bus.dir[win_idx];
                        prev    <= bus.count_in;
                        ptr     <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        inc_q   <= (bus.dir[win_idx] == DIR_UP);
                        dec_q   <= (bus.dir[win_idx] == DIR_DN);
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_q <= grant_q;
                    state <= WAIT;
                end
                WAIT: begin
                    count_hold <= bus.count_in;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The counter has already absorbed the pulse in WAIT, so the ack payload
    // is taken straight from count_in; outside WAIT the last value is held.
    assign in_wait = (state == WAIT);
    assign at_edge = (dir_g == DIR_UP) ? (prev == '1) : (prev == '0);

    assign bus.ack              = ack_q;
    assign bus.increase         = inc_q;
    assign bus.decrease         = dec_q;
    assign bus.busy             = busy_q;
    assign bus.ack_count        = in_wait ? bus.count_in : count_hold;
    assign bus.ack_sat          = in_wait & PROTECT & (bus.count_in == prev);
    assign bus.ack_wrap         = in_wait & ~PROTECT & at_edge;
    assign bus.overflow_protect = PROTECT;
endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: a saturating (k=0) and a wrapping (k=1)
// controller, each driving its own 16-bit counter, checked against an op-level model.
module tb_counter_share_ctrl;
    localparam logic [1:0] PROT = 2'b01;

    typedef struct {
        int          k;
        int          g;
        logic [15:0] c;
        logic        s;
        logic        w;
        int          cyc;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_t[2];
    logic [3:0]  dir_t[2];
    logic [3:0]  ack_t[2];
    logic [3:0]  drop_mask[2];
    logic [15:0] ackc_t[2];
    logic [15:0] cnt[2] = '{16'h0000, 16'h0000};
    logic [15:0] load_val[2];
    logic        load_en[2];
    logic        inc_t[2], dec_t[2], busy_t[2], sat_t[2], wrap_t[2], op_t[2];

    int          checks = 0;
    int          errors = 0;
    int          ev_n[2] = '{0, 0};
    int          last_inc_cyc[2] = '{-1, -1};
    ev_t         evq[$];

    // Model state: m_age = -1 no op, 0 pulse cycle, 1 ack cycle.
    int          cyc = 0;
    int          m_age[2] = '{-1, -1};
    int          m_ptr[2] = '{0, 0};
    int          m_g[2] = '{0, 0};
    logic        m_up[2] = '{1'b0, 1'b0};
    logic [15:0] m_prev[2] = '{16'h0000, 16'h0000};
    logic [15:0] m_cnt[2] = '{16'h0000, 16'h0000};

    always #5 clock = ~clock;

    counter_share_ctrl_if #(.N_REQ(4), .WIDTH(16)) ifa ();
    counter_share_ctrl_if #(.N_REQ(4), .WIDTH(16)) ifb ();

    counter_share_ctrl #(.N_REQ(4), .WIDTH(16), .PROTECT(1'b1)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa.master));
    counter_share_ctrl #(.N_REQ(4), .WIDTH(16), .PROTECT(1'b0)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb.master));

    assign ifa.req = req_t[0];
    assign ifa.dir = dir_t[0];
    assign ifa.count_in = cnt[0];
    assign ifb.req = req_t[1];
    assign ifb.dir = dir_t[1];
    assign ifb.count_in = cnt[1];
    assign ack_t[0] = ifa.ack;      assign ack_t[1] = ifb.ack;
    assign ackc_t[0] = ifa.ack_count; assign ackc_t[1] = ifb.ack_count;
    assign inc_t[0] = ifa.increase; assign inc_t[1] = ifb.increase;
    assign dec_t[0] = ifa.decrease; assign dec_t[1] = ifb.decrease;
    assign busy_t[0] = ifa.busy;    assign busy_t[1] = ifb.busy;
    assign sat_t[0] = ifa.ack_sat;  assign sat_t[1] = ifb.ack_sat;
    assign wrap_t[0] = ifa.ack_wrap; assign wrap_t[1] = ifb.ack_wrap;
    assign op_t[0] = ifa.overflow_protect; assign op_t[1] = ifb.overflow_protect;

    // External counters: no reset, bench-side load, pulse applied on the next edge.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (load_en[k])
                cnt[k] <= load_val[k];
            else if (inc_t[k] && !dec_t[k])
                cnt[k] <= (cnt[k] == 16'hFFFF) ? (op_t[k] ? cnt[k] : 16'h0000) : cnt[k] + 16'd1;
            else if (dec_t[k] && !inc_t[k])
                cnt[k] <= (cnt[k] == 16'h0000) ? (op_t[k] ? cnt[k] : 16'hFFFF) : cnt[k] - 16'd1;
        end
    end

    function automatic logic [15:0] step(input logic [15:0] v, input logic up, input logic prot);
        int n;
        n = up ? int'(v) + 1 : int'(v) - 1;
        if (n > 65535 || n < 0) return prot ? v : 16'(n & 16'hFFFF);
        return 16'(n);
    endfunction

    always @(posedge clock or posedge reset) begin
        int  g;
        bit  found;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_age[k] = -1;
                m_ptr[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (load_en[k]) m_cnt[k] = load_val[k];
                if (m_age[k] == 0) begin
                    m_cnt[k] = step(m_cnt[k], m_up[k], PROT[k]);
                    m_age[k] = 1;
                end else if (m_age[k] == 1) begin
                    m_age[k] = -1;
                end else if (req_t[k] != 4'b0000) begin
                    found = 0;
                    g = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (!found && req_t[k][(m_ptr[k] + i) % 4]) begin
                            found = 1;
                            g = (m_ptr[k] + i) % 4;
                        end
                    end
                    m_g[k]    = g;
                    m_up[k]   = dir_t[k][g];
                    m_prev[k] = m_cnt[k];
                    m_ptr[k]  = (g + 1) % 4;
                    m_age[k]  = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every negedge: compare against the model, log acks, then requesters drop on ack.
    task automatic tick();
        ev_t        ev;
        logic [3:0] e_ack;
        logic       hit;
        @(negedge clock);
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                e_ack = (m_age[k] == 1) ? (4'b0001 << m_g[k]) : 4'b0000;
                chk($sformatf("inc%0d", k), inc_t[k], (m_age[k] == 0) && m_up[k]);
                chk($sformatf("dec%0d", k), dec_t[k], (m_age[k] == 0) && !m_up[k]);
                chk($sformatf("busy%0d", k), busy_t[k], m_age[k] >= 0);
                chk($sformatf("ack%0d", k), ack_t[k], e_ack);
                chk($sformatf("excl%0d", k), inc_t[k] & dec_t[k], 0);
                if (m_age[k] == 1) begin
                    hit = m_up[k] ? (m_prev[k] == 16'hFFFF) : (m_prev[k] == 16'h0000);
                    chk($sformatf("count%0d", k), ackc_t[k], m_cnt[k]);
                    chk($sformatf("sat%0d", k), sat_t[k], PROT[k] && hit);
                    chk($sformatf("wrap%0d", k), wrap_t[k], !PROT[k] && hit);
                end
                if (inc_t[k]) last_inc_cyc[k] = cyc;
                if (ack_t[k] != 4'b0000) begin
                    ev.k = k;
                    ev.g = -1;
                    for (int i = 0; i < 4; i++) if (ack_t[k][i]) ev.g = i;
                    ev.c = ackc_t[k];
                    ev.s = sat_t[k];
                    ev.w = wrap_t[k];
                    ev.cyc = cyc;
                    evq.push_back(ev);
                    ev_n[k]++;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            req_t[k] = req_t[k] & ~(ack_t[k] & drop_mask[k]);
            load_en[k] = 1'b0;
        end
    endtask

    task automatic load(input int k, input logic [15:0] v);
        load_val[k] = v;
        load_en[k] = 1'b1;
        tick();
    endtask

    task automatic wait_ev(input int k, input int n);
        for (int i = 0; i < 100 && ev_n[k] < n; i++) tick();
        if (ev_n[k] < n) chk("ack_timeout", ev_n[k], n);
    endtask

    task automatic op(input int k, input int r, input logic up);
        int n;
        n = ev_n[k];
        req_t[k][r] = 1'b1;
        dir_t[k][r] = up;
        wait_ev(k, n + 1);
    endtask

    task automatic check_ev(input string nm, input int idx, input int g,
                            input logic [15:0] c, input logic s, input logic w);
        if (idx >= evq.size()) begin
            chk({nm, "_missing"}, evq.size(), idx + 1);
        end else begin
            chk({nm, "_g"}, evq[idx].g, g);
            chk({nm, "_count"}, evq[idx].c, c);
            chk({nm, "_sat"}, evq[idx].s, s);
            chk({nm, "_wrap"}, evq[idx].w, w);
        end
    endtask

    initial begin
        int base, c0, n;
        for (int k = 0; k < 2; k++) begin
            req_t[k] = 4'b0000;
            dir_t[k] = 4'b0000;
            drop_mask[k] = 4'b1111;
            load_en[k] = 1'b0;
            load_val[k] = 16'h0000;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", ack_t[k], 0);
            chk("rst_count", ackc_t[k], 0);
            chk("rst_busy", busy_t[k], 0);
            chk("rst_inc", inc_t[k], 0);
            chk("rst_dec", dec_t[k], 0);
            chk("rst_sat", sat_t[k], 0);
            chk("rst_wrap", wrap_t[k], 0);
        end
        chk("protect_a", op_t[0], 1);
        chk("protect_b", op_t[1], 0);
        reset = 1'b0;
        tick();

        // Single up op with latency check
        load(0, 16'd5);
        c0 = cyc;
        base = evq.size();
        op(0, 0, 1'b1);
        check_ev("single", base, 0, 16'd6, 1'b0, 1'b0);
        if (evq.size() > base) chk("single_ack_cyc", evq[base].cyc, c0 + 2);
        chk("single_inc_cyc", last_inc_cyc[0], c0 + 1);

        // Contention: all four up from 0
        load(1, 16'd0);
        base = evq.size();
        n = ev_n[1];
        req_t[1] = 4'b1111;
        dir_t[1] = 4'b1111;
        wait_ev(1, n + 4);
        for (int i = 0; i < 4; i++) begin
            check_ev("contend", base + i, i, 16'(i + 1), 1'b0, 1'b0);
            if (i > 0 && evq.size() > base + i)
                chk("contend_gap", evq[base + i].cyc - evq[base + i - 1].cyc, 3);
        end

        // Boundaries: saturate on k=0, wrap on k=1
        load(0, 16'hFFFF);
        base = evq.size();
        op(0, 1, 1'b1);
        check_ev("sat_top", base, 1, 16'hFFFF, 1'b1, 1'b0);
        load(0, 16'h0000);
        base = evq.size();
        op(0, 2, 1'b0);
        check_ev("sat_bot", base, 2, 16'h0000, 1'b1, 1'b0);
        load(1, 16'hFFFF);
        base = evq.size();
        op(1, 0, 1'b1);
        check_ev("wrap_top", base, 0, 16'h0000, 1'b0, 1'b1);
        base = evq.size();
        op(1, 1, 1'b0);
        check_ev("wrap_bot", base, 1, 16'hFFFF, 1'b0, 1'b1);

        // Reset while the pulse is out
        load(0, 16'd100);
        n = ev_n[0];
        req_t[0] = 4'b0010;
        dir_t[0] = 4'b0010;
        for (int i = 0; i < 20 && !inc_t[0]; i++) tick();
        chk("issue_seen", inc_t[0], 1);
        reset = 1'b1;
        #1;
        chk("rst_cut_inc", inc_t[0], 0);
        chk("rst_cut_busy", busy_t[0], 0);
        req_t[0] = 4'b0000;
        tick();
        chk("rst_no_ack", ack_t[0], 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_ev", ev_n[0], n);
        chk("rst_count_kept", cnt[0], 16'd100);
        base = evq.size();
        req_t[0] = 4'b1010;
        dir_t[0] = 4'b1010;
        wait_ev(0, n + 2);
        check_ev("rst_ptr", base, 1, 16'd101, 1'b0, 1'b0);
        check_ev("rst_next", base + 1, 3, 16'd102, 1'b0, 1'b0);
        base = evq.size();
        op(0, 2, 1'b1);
        check_ev("rst_req2", base, 2, 16'd103, 1'b0, 1'b0);

        // Fairness: req[0] re-raised after each ack, req[2] held
        drop_mask[0] = 4'b0001;
        base = evq.size();
        req_t[0] = 4'b0101;
        dir_t[0] = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            wait_ev(0, ev_n[0] + 1);
            tick();
            req_t[0][0] = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            if (evq.size() > base + i)
                chk("fair_g", evq[base + i].g, (i % 2 == 0) ? 0 : 2);
        end
        req_t[0] = 4'b0000;
        drop_mask[0] = 4'b1111;
        repeat (6) tick();

        // Random traffic near the boundaries
        load(0, 16'hFFFD);
        load(1, 16'h0002);
        for (int t = 0; t < 500; t++) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 4; r++) begin
                    if (!req_t[k][r] && $urandom_range(3) == 0) begin
                        dir_t[k][r] = 1'($urandom_range(1));
                        req_t[k][r] = 1'b1;
                    end
                end
            end
            tick();
        end
        req_t[0] = 4'b0000;
        req_t[1] = 4'b0000;
        repeat (6) tick();
        chk("end_idle_a", busy_t[0], 0);
        chk("end_idle_b", busy_t[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
